// File: rtl/hamming_pkg.sv
// Shared types, constants and Hamming(7,4) helpers for the serial injection link.
package hamming_pkg;

    localparam int         CW_W       = 7;
    localparam int         DATA_W     = 4;
    localparam logic [2:0] PAD_POS    = 3'd7;
    localparam logic [2:0] NO_ERR_POS = 3'd7;

    typedef enum logic [2:0] {
        SYNC_SETUP,
        SYNC_HI,
        SYNC_LO,
        IDLE,
        SETUP,
        HI,
        LO,
        DONE
    } link_state_t;

    function automatic logic [CW_W-1:0] encode74(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        cw[0] = d[0] ^ d[1] ^ d[3];
        cw[1] = d[0] ^ d[2] ^ d[3];
        cw[2] = d[0];
        cw[3] = d[1] ^ d[2] ^ d[3];
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        return cw;
    endfunction

    // Result is {s4,s2,s1}: zero for a clean word, otherwise the bad index plus one.
    function automatic logic [2:0] syndrome74(input logic [CW_W-1:0] r);
        logic s1;
        logic s2;
        logic s4;
        s1 = r[0] ^ r[2] ^ r[4] ^ r[6];
        s2 = r[1] ^ r[2] ^ r[5] ^ r[6];
        s4 = r[3] ^ r[4] ^ r[5] ^ r[6];
        return {s4, s2, s1};
    endfunction

endpackage

// File: rtl/hamming74_decode.sv
// Combinational Hamming(7,4) decoder: syndrome plus single-bit-corrected nibble.
module hamming74_decode
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]   rx_word,
    output logic [2:0]        syndrome,
    output logic [DATA_W-1:0] data_corr
);

    logic [2:0]      syn;
    logic [CW_W-1:0] fixed;

    always_comb begin
        syn   = syndrome74(rx_word);
        fixed = rx_word;
        if (syn != 3'd0) begin
            fixed[syn - 3'd1] = ~fixed[syn - 3'd1];
        end
        syndrome  = syn;
        data_corr = {fixed[6], fixed[5], fixed[4], fixed[2]};
    end

endmodule

// File: rtl/hamming_serial_link_ctrl.sv
// Sequencer for the strobe-clocked error-injection stage: encodes and serializes a nibble,
// captures the injector's returned word, decodes it, and realigns the injector after reset.
module hamming_serial_link_ctrl
    import hamming_pkg::*;
#(
    parameter bit SYNC_ON_RESET = 1'b1,
    parameter int SYNC_LIMIT    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_i,
    input  logic [2:0]        err_pos_i,
    output logic              d_ser,
    output logic              strobe_o,
    output logic [2:0]        error_pos_o,
    input  logic              d_ret,
    input  logic              strobe_ret,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   rx_word,
    output logic [2:0]        syndrome,
    output logic [DATA_W-1:0] data_corr,
    output logic              sync_err,
    output logic              proto_err
);

    localparam int               CNT_W     = $clog2(SYNC_LIMIT + 1);
    localparam logic [CNT_W-1:0] SYNC_MAX  = CNT_W'(SYNC_LIMIT);
    localparam logic [3:0]       PAD_CNT   = {1'b0, PAD_POS};
    localparam logic [3:0]       LAST_DATA = PAD_CNT - 4'd1;
    localparam logic [3:0]       FRAME_END = PAD_CNT + 4'd1;
    localparam link_state_t      RESET_STATE = SYNC_ON_RESET ? SYNC_SETUP : IDLE;

    link_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              sync_hit, sync_hit_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic [CW_W-2:0]   tx_sh, tx_nxt;
    logic [CW_W-1:0]   rx_sh, rx_nxt;
    logic              d_ser_nxt, strobe_nxt, in_ready_nxt, out_valid_nxt;
    logic              sync_err_nxt, proto_err_nxt;
    logic [2:0]        error_pos_nxt, syndrome_nxt;
    logic [CW_W-1:0]   rx_word_nxt, cw_new;
    logic [DATA_W-1:0] data_corr_nxt;
    logic [2:0]        dec_syndrome;
    logic [DATA_W-1:0] dec_data;

    assign cw_new = encode74(data_i);

    hamming74_decode u_decode (
        .rx_word   (rx_sh),
        .syndrome  (dec_syndrome),
        .data_corr (dec_data)
    );

    // Every output is a register; this block computes their next values alongside the state.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        sync_hit_nxt  = sync_hit;
        bit_cnt_nxt   = bit_cnt;
        tx_nxt        = tx_sh;
        rx_nxt        = rx_sh;
        d_ser_nxt     = d_ser;
        error_pos_nxt = error_pos_o;
        out_valid_nxt = out_valid;
        rx_word_nxt   = rx_word;
        syndrome_nxt  = syndrome;
        data_corr_nxt = data_corr;
        sync_err_nxt  = sync_err;
        proto_err_nxt = proto_err;

        case (state)
            SYNC_SETUP: begin
                d_ser_nxt     = 1'b0;
                error_pos_nxt = NO_ERR_POS;
                cnt_nxt       = '0;
                sync_hit_nxt  = 1'b0;
                state_nxt     = SYNC_HI;
            end
            // With d_ser=0 and error_pos=7 the injector only returns 1 on its pad slot.
            SYNC_HI: begin
                state_nxt    = SYNC_LO;
                sync_hit_nxt = d_ret;
                if (!d_ret) cnt_nxt = cnt + 1'b1;
                if (!strobe_ret) proto_err_nxt = 1'b1;
            end
            SYNC_LO: begin
                if (sync_hit) begin
                    state_nxt = IDLE;
                end else if (cnt == SYNC_MAX) begin
                    sync_err_nxt = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    state_nxt = SYNC_HI;
                end
            end
            IDLE: begin
                if (in_valid && in_ready) begin
                    tx_nxt        = cw_new[CW_W-2:0];
                    d_ser_nxt     = cw_new[CW_W-1];
                    error_pos_nxt = err_pos_i;
                    bit_cnt_nxt   = 4'd0;
                    state_nxt     = SETUP;
                end
            end
            SETUP: state_nxt = HI;
            // Falling strobe edge: capture, then present the next bit (or the pad, flip disabled).
            HI: begin
                state_nxt   = LO;
                bit_cnt_nxt = bit_cnt + 4'd1;
                if (!strobe_ret) proto_err_nxt = 1'b1;
                if (bit_cnt < PAD_CNT) rx_nxt = {rx_sh[CW_W-2:0], d_ret};
                if (bit_cnt < LAST_DATA) begin
                    d_ser_nxt = tx_sh[CW_W-2];
                    tx_nxt    = {tx_sh[CW_W-3:0], 1'b0};
                end else begin
                    d_ser_nxt = 1'b0;
                    if (bit_cnt == LAST_DATA) error_pos_nxt = 3'd0;
                end
            end
            LO: begin
                if (bit_cnt == FRAME_END) begin
                    state_nxt     = DONE;
                    out_valid_nxt = 1'b1;
                    rx_word_nxt   = rx_sh;
                    syndrome_nxt  = dec_syndrome;
                    data_corr_nxt = dec_data;
                end else begin
                    state_nxt = HI;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = RESET_STATE;
        endcase

        strobe_nxt   = (state_nxt == SYNC_HI) || (state_nxt == HI);
        in_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RESET_STATE;
            cnt         <= '0;
            sync_hit    <= 1'b0;
            bit_cnt     <= 4'd0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            in_ready    <= 1'b0;
            d_ser       <= 1'b0;
            strobe_o    <= 1'b0;
            error_pos_o <= 3'd0;
            out_valid   <= 1'b0;
            rx_word     <= '0;
            syndrome    <= 3'd0;
            data_corr   <= '0;
            sync_err    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sync_hit    <= sync_hit_nxt;
            bit_cnt     <= bit_cnt_nxt;
            tx_sh       <= tx_nxt;
            rx_sh       <= rx_nxt;
            in_ready    <= in_ready_nxt;
            d_ser       <= d_ser_nxt;
            strobe_o    <= strobe_nxt;
            error_pos_o <= error_pos_nxt;
            out_valid   <= out_valid_nxt;
            rx_word     <= rx_word_nxt;
            syndrome    <= syndrome_nxt;
            data_corr   <= data_corr_nxt;
            sync_err    <= sync_err_nxt;
            proto_err   <= proto_err_nxt;
        end
    end

endmodule

// File: tb/tb_hamming_serial_link_ctrl.sv
// Directed bench for hamming_serial_link_ctrl with a behavioural model of the
// non-resettable strobe-clocked error injector on the far side of the link.
module tb_hamming_serial_link_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data_i;
    logic [2:0] err_pos_i;
    logic       d_ser;
    logic       strobe_o;
    logic [2:0] error_pos_o;
    logic       d_ret;
    logic       strobe_ret;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] rx_word;
    logic [2:0] syndrome;
    logic [3:0] data_corr;
    logic       sync_err;
    logic       proto_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0] inj_cnt;
    logic       inj_q;
    logic       inj_load     = 1'b0;
    logic [2:0] inj_load_val = 3'd6;
    int         strobe_count = 0;
    logic       stuck_d0     = 1'b0;
    logic       tie_strobe0  = 1'b0;

    always #5 clk = ~clk;

    hamming_serial_link_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_i      (data_i),
        .err_pos_i   (err_pos_i),
        .d_ser       (d_ser),
        .strobe_o    (strobe_o),
        .error_pos_o (error_pos_o),
        .d_ret       (d_ret),
        .strobe_ret  (strobe_ret),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rx_word     (rx_word),
        .syndrome    (syndrome),
        .data_corr   (data_corr),
        .sync_err    (sync_err),
        .proto_err   (proto_err)
    );

    // Injector: on each strobe rise, flip d_in when the position counter matches, then count down.
    always @(posedge strobe_o or posedge inj_load) begin
        if (inj_load) begin
            inj_cnt <= inj_load_val;
            inj_q   <= 1'b0;
        end else begin
            inj_q        <= d_ser ^ (inj_cnt == error_pos_o);
            inj_cnt      <= inj_cnt - 3'd1;
            strobe_count <= strobe_count + 1;
        end
    end

    assign d_ret      = stuck_d0 ? 1'b0 : inj_q;
    assign strobe_ret = tie_strobe0 ? 1'b0 : strobe_o;

    task automatic wait_ready(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (in_ready) return;
            @(negedge clk);
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ready_timeout: in_ready=%b after %0d cycles, want 1", in_ready, max_cycles);
        end
    endtask

    task automatic assert_reset(input bit load, input logic [2:0] start_cnt);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (load) begin
            inj_load_val = start_cnt;
            inj_load     = 1'b1;
            #1;
            inj_load     = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset(output int strobes);
        int base;
        base  = strobe_count;
        rst_n = 1'b1;
        @(negedge clk);
        wait_ready(100);
        strobes = strobe_count - base;
    endtask

    // Caller is at a negedge; returns the number of clocks from accept until out_valid is seen.
    task automatic send_frame(input logic [3:0] d, input logic [2:0] ep, output int lat);
        in_valid  = 1'b1;
        data_i    = d;
        err_pos_i = ep;
        wait_ready(60);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: out_valid=%b after %0d cycles, want 1", out_valid, lat);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int strobes;
        assert_reset(1'b1, 3'd6);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_in_ready: got %b want 0", in_ready); end
        vectors++; if (d_ser !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_d_ser: got %b want 0", d_ser); end
        vectors++; if (strobe_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_strobe: got %b want 0", strobe_o); end
        vectors++; if (error_pos_o !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_error_pos: got %0d want 0", error_pos_o); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
        vectors++; if (rx_word !== 7'd0) begin miscompares++; $display("[TB] FAIL rst_rx_word: got %b want 0000000", rx_word); end
        vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_sync_err: got %b want 0", sync_err); end
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_proto_err: got %b want 0", proto_err); end
        release_reset(strobes);
        vectors++; if (strobes != 8) begin miscompares++; $display("[TB] FAIL sync6_strobes: got %0d want 8", strobes); end
        vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("[TB] FAIL sync6_err: got %b want 0", sync_err); end
        vectors++; if (inj_cnt !== 3'd6) begin miscompares++; $display("[TB] FAIL sync6_align: got %0d want 6", inj_cnt); end
    endtask

    task automatic test_sync_from3();
        int strobes;
        assert_reset(1'b1, 3'd3);
        release_reset(strobes);
        vectors++; if (strobes != 5) begin miscompares++; $display("[TB] FAIL sync3_strobes: got %0d want 5", strobes); end
        vectors++; if (inj_cnt !== 3'd6) begin miscompares++; $display("[TB] FAIL sync3_align: got %0d want 6", inj_cnt); end
        vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("[TB] FAIL sync3_err: got %b want 0", sync_err); end
    endtask

    task automatic test_clean_frame();
        int lat;
        send_frame(4'b1011, 3'd7, lat);
        vectors++; if (lat != 17) begin miscompares++; $display("[TB] FAIL clean_latency: got %0d want 17", lat); end
        vectors++; if (rx_word !== 7'b1010101) begin miscompares++; $display("[TB] FAIL clean_rx: got %b want 1010101", rx_word); end
        vectors++; if (syndrome !== 3'd0) begin miscompares++; $display("[TB] FAIL clean_syndrome: got %0d want 0", syndrome); end
        vectors++; if (data_corr !== 4'b1011) begin miscompares++; $display("[TB] FAIL clean_data: got %b want 1011", data_corr); end
        release_result();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL clean_release: out_valid=%b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL clean_idle: in_ready=%b want 1", in_ready); end
    endtask

    task automatic test_single_error();
        int lat;
        send_frame(4'b1011, 3'd2, lat);
        vectors++; if (rx_word !== 7'b1010001) begin miscompares++; $display("[TB] FAIL err2_rx: got %b want 1010001", rx_word); end
        vectors++; if (syndrome !== 3'd3) begin miscompares++; $display("[TB] FAIL err2_syndrome: got %0d want 3", syndrome); end
        vectors++; if (data_corr !== 4'b1011) begin miscompares++; $display("[TB] FAIL err2_data: got %b want 1011", data_corr); end
        vectors++; if (inj_cnt !== 3'd6) begin miscompares++; $display("[TB] FAIL err2_align: got %0d want 6", inj_cnt); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        send_frame(4'b1100, 3'd5, lat);
        vectors++; if (rx_word !== 7'b1000001) begin miscompares++; $display("[TB] FAIL err5_rx: got %b want 1000001", rx_word); end
        vectors++; if (syndrome !== 3'd6) begin miscompares++; $display("[TB] FAIL err5_syndrome: got %0d want 6", syndrome); end
        vectors++; if (data_corr !== 4'b1100) begin miscompares++; $display("[TB] FAIL err5_data: got %b want 1100", data_corr); end
        // New request is offered while the result is still held; it must wait.
        in_valid  = 1'b1;
        data_i    = 4'b0000;
        err_pos_i = 3'd6;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_valid[%0d]: got %b want 1", c, out_valid); end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_ready[%0d]: got %b want 0", c, in_ready); end
            vectors++; if (rx_word !== 7'b1000001 || syndrome !== 3'd6 || data_corr !== 4'b1100) begin
                miscompares++;
                $display("[TB] FAIL hold_stable[%0d]: got rx=%b syn=%0d data=%b want rx=1000001 syn=6 data=1100", c, rx_word, syndrome, data_corr);
            end
        end
        release_result();
        send_frame(4'b0000, 3'd6, lat);
        vectors++; if (lat != 17) begin miscompares++; $display("[TB] FAIL b2b_latency: got %0d want 17", lat); end
        vectors++; if (rx_word !== 7'b1000000) begin miscompares++; $display("[TB] FAIL b2b_rx: got %b want 1000000", rx_word); end
        vectors++; if (syndrome !== 3'd7) begin miscompares++; $display("[TB] FAIL b2b_syndrome: got %0d want 7", syndrome); end
        vectors++; if (data_corr !== 4'b0000) begin miscompares++; $display("[TB] FAIL b2b_data: got %b want 0000", data_corr); end
        release_result();
    endtask

    task automatic test_proto_err();
        int lat;
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("[TB] FAIL proto_pre: got %b want 0", proto_err); end
        tie_strobe0 = 1'b1;
        send_frame(4'b1011, 3'd7, lat);
        vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("[TB] FAIL proto_set: got %b want 1", proto_err); end
        release_result();
        tie_strobe0 = 1'b0;
        send_frame(4'b0110, 3'd4, lat);
        vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("[TB] FAIL proto_sticky: got %b want 1", proto_err); end
        vectors++; if (rx_word !== 7'b0100011) begin miscompares++; $display("[TB] FAIL err4_rx: got %b want 0100011", rx_word); end
        vectors++; if (syndrome !== 3'd5) begin miscompares++; $display("[TB] FAIL err4_syndrome: got %0d want 5", syndrome); end
        vectors++; if (data_corr !== 4'b0110) begin miscompares++; $display("[TB] FAIL err4_data: got %b want 0110", data_corr); end
        release_result();
    endtask

    task automatic test_sync_stuck();
        int strobes;
        stuck_d0 = 1'b1;
        assert_reset(1'b0, 3'd0);
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("[TB] FAIL proto_cleared: got %b want 0", proto_err); end
        release_reset(strobes);
        vectors++; if (strobes != 8) begin miscompares++; $display("[TB] FAIL stuck_strobes: got %0d want 8", strobes); end
        vectors++; if (sync_err !== 1'b1) begin miscompares++; $display("[TB] FAIL stuck_sync_err: got %b want 1", sync_err); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stuck_idle: got %b want 1", in_ready); end
        stuck_d0 = 1'b0;
        assert_reset(1'b0, 3'd0);
        release_reset(strobes);
        vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("[TB] FAIL resync_err: got %b want 0", sync_err); end
        vectors++; if (strobes != 8) begin miscompares++; $display("[TB] FAIL resync_strobes: got %0d want 8", strobes); end
    endtask

    task automatic test_midframe_reset();
        int base;
        int strobes;
        int lat;
        int guard;
        in_valid  = 1'b1;
        data_i    = 4'b1011;
        err_pos_i = 3'd7;
        wait_ready(60);
        @(posedge clk);
        base = strobe_count;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!(strobe_o && (strobe_count - base) == 4) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        vectors++; if (guard >= 40) begin miscompares++; $display("[TB] FAIL mid_reach_bit3: strobes=%0d want 4", strobe_count - base); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (strobe_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_strobe: got %b want 0", strobe_o); end
        vectors++; if (error_pos_o !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_error_pos: got %0d want 0", error_pos_o); end
        vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_handshake: got in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
        end
        vectors++; if (inj_cnt !== 3'd2) begin miscompares++; $display("[TB] FAIL mid_inj_pos: got %0d want 2", inj_cnt); end
        assert_reset(1'b0, 3'd0);
        release_reset(strobes);
        vectors++; if (strobes != 4) begin miscompares++; $display("[TB] FAIL mid_resync_strobes: got %0d want 4", strobes); end
        vectors++; if (inj_cnt !== 3'd6) begin miscompares++; $display("[TB] FAIL mid_resync_align: got %0d want 6", inj_cnt); end
        send_frame(4'b0110, 3'd4, lat);
        vectors++; if (lat != 17) begin miscompares++; $display("[TB] FAIL mid_latency: got %0d want 17", lat); end
        vectors++; if (rx_word !== 7'b0100011) begin miscompares++; $display("[TB] FAIL mid_rx: got %b want 0100011", rx_word); end
        vectors++; if (syndrome !== 3'd5 || data_corr !== 4'b0110) begin
            miscompares++;
            $display("[TB] FAIL mid_decode: got syn=%0d data=%b want syn=5 data=0110", syndrome, data_corr);
        end
        release_result();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_i    = 4'd0;
        err_pos_i = 3'd7;
        test_reset();
        test_sync_from3();
        test_clean_frame();
        test_single_error();
        test_back_to_back();
        test_proto_err();
        test_sync_stuck();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hamming_serial_link_ctrl.md
Name: hamming_serial_link_ctrl

Overview:
Sequencer for the serial, strobe-clocked error-injection stage of the Hamming(7,4) lab datapath.
- Accepts a 4-bit nibble and a per-frame error position, encodes it to a 7-bit codeword, and serializes it MSB (index 6) first.
- Drives the injector's d_in, strobe_in and error_pos, and captures the returned d_out/strobe_out into a 7-bit received word.
- Reports the received word, syndrome and corrected nibble.
- Also realigns the injector's non-resettable position counter after reset.

Parameters:
- SYNC_ON_RESET, 1, run the alignment sequence after reset (0 = go straight to IDLE).
- SYNC_LIMIT, 8, maximum alignment strobes before giving up.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  nibble offered
- in_ready  out  1  controller can accept (IDLE only)
- data_i  in  4  nibble d3..d0
- err_pos_i  in  3  codeword index to corrupt; 7 = no injection
- d_ser  out  1  to injector d_in
- strobe_o  out  1  to injector strobe_in
- error_pos_o  out  3  to injector error_pos
- d_ret  in  1  from injector d_out
- strobe_ret  in  1  from injector strobe_out
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- rx_word  out  7  received codeword
- syndrome  out  3  {s4,s2,s1}; 0 = clean, else error index + 1
- data_corr  out  4  corrected nibble
- sync_err  out  1  sticky: alignment failed
- proto_err  out  1  sticky: strobe_ret low at a capture edge

Behaviour:
- Reset values: in_ready=0, d_ser=0, strobe_o=0, error_pos_o=0, out_valid=0, rx_word=0, sync_err=0, proto_err=0. All outputs are registered.
- Reset is asynchronous and takes effect at any time, including mid-frame. State then goes to SYNC_SETUP (SYNC_ON_RESET=1) or IDLE.
- Encoding: cw[0]=p1=d0^d1^d3, cw[1]=p2=d0^d2^d3, cw[2]=d0, cw[3]=p4=d1^d2^d3, cw[4]=d1, cw[5]=d2, cw[6]=d3.
- Injector model: the injector's 3-bit position counter starts at 6 and decrements (mod 8) per strobe rise. It flips the bit when counter == error_pos. Each frame issues 8 strobes (7 data + 1 pad at counter 7) so the counter returns to 6.
- Bit timing: 2 clk per strobe, HI then LO.
  - d_ser and error_pos_o change only on the edge entering LO or SETUP, never with the strobe rise.
  - d_ret is sampled on the HI->LO edge. strobe_ret must be 1 at that edge; otherwise set proto_err.
- FSM states: SYNC_SETUP, SYNC_HI, SYNC_LO, IDLE, SETUP, HI, LO, DONE.
- SYNC_SETUP: d_ser=0, error_pos_o=7, cnt=0. Then go to SYNC_HI.
- SYNC_HI / SYNC_LO: pulse the strobe.
  - If the sampled d_ret=1, the injector is now at 6: go to IDLE.
  - Otherwise cnt++. If cnt==SYNC_LIMIT, set sync_err and go to IDLE.
- IDLE: in_ready=1. On in_valid, latch the codeword and err_pos_i, set bit=0, d_ser=cw[6], error_pos_o=err_pos_i. Then go to SETUP.
- SETUP: one cycle, then HI.
- HI: strobe_o=1.
- LO: strobe_o=0.
  - The bit sampled on the HI->LO edge shifts into rx (bits 0..6 only; the pad bit is discarded).
  - bit++. d_ser becomes cw[6-bit], or 0 for the pad.
  - For the pad, error_pos_o=0 so no flip occurs.
  - After the pad's LO, go to DONE; otherwise go back to HI.
- Latency: accept edge E0 -> DONE entered at E17; out_valid is high from the cycle after E17.
- DONE: out_valid=1. rx_word, syndrome and data_corr are held stable until out_ready=1, then go to IDLE. No accept in the same cycle; the next accept is no earlier than the following cycle.
- Syndrome: s1=r0^r2^r4^r6, s2=r1^r2^r5^r6, s4=r3^r4^r5^r6. data_corr = {r6,r5,r4,r2} after flipping r[syndrome-1] when syndrome≠0.
- in_valid outside IDLE is ignored and not queued.

Decomposition:
- Package hamming_pkg holds:
  - the state enum;
  - constants CW_W=7, DATA_W=4, PAD_POS=7, NO_ERR_POS=7;
  - functions encode74 and syndrome74.
- Sub-module hamming74_decode (combinational): rx_word -> syndrome, data_corr.

Test Plan:
- Reset with the injector model at 6 -> exactly 8 sync strobes, 8th d_ret=1, IDLE with sync_err=0. Model at 3 -> 5 strobes.
- data_i=4'b1011, err_pos_i=7 -> rx_word=7'b1010101, syndrome=0, data_corr=4'b1011, out_valid 17 cycles after accept.
- data_i=4'b1011, err_pos_i=2 -> rx_word=7'b1010001, syndrome=3, data_corr=4'b1011. The injector model is back at 6 after the frame.
- out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0. Back-to-back frame 4'b0000 err 6 -> rx=7'b1000000, syndrome=7, data_corr=4'b0000.
- Injector model tied strobe_ret=0 -> proto_err=1 (sticky). Sync with d_ret stuck 0 -> sync_err=1 after 8 strobes, IDLE reached.
- rst_n asserted at bit 3 of a frame -> immediate reset values, resync recovers alignment, next frame decodes correctly.
